data_mem_pipe: RTL
==================

DATA_MEM_PIPE -- requirements
Module: data_mem_pipe

Interface
REQ-001 SHALL have parameter DEPTH, default 3072, memory size in 32-bit words.
REQ-002 SHALL have parameter BASE, default 32'h0000_0000, byte address of word 0.
REQ-003 SHALL have port Clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port Reset  in  1  one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port Req  in  1  request valid.
REQ-006 SHALL have port We  in  1  1 = store, 0 = load.
REQ-007 SHALL have port Addr  in  32  byte address.
REQ-008 SHALL have port WData  in  32  store data, right-aligned.
REQ-009 SHALL have port Size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
REQ-010 SHALL have port Signed  in  1  load sign-extension select.
REQ-011 SHALL have port PC  in  32  instruction address, for store trace only.
REQ-012 SHALL have port Ready  out  1  request accepted when Req && Ready at a rising edge.
REQ-013 SHALL have port Ack  out  1  one-cycle completion pulse per accepted request.
REQ-014 SHALL have port RData  out  32  load result, valid while Ack && !We of that request.
REQ-015 SHALL have port Exc  out  2  00 ok, 01 misaligned, 10 out of range; valid with Ack.

Function
REQ-016 SHALL implement FSM states CLEAR and RUN; Ready = 1 only in RUN.
REQ-017 SHALL, in CLEAR, zero one word per cycle via index counter 0..DEPTH-1, then enter RUN on the cycle after index DEPTH-1 is written (DEPTH cycles total).
REQ-018 SHALL, in RUN, accept one request per cycle with no bubbles.
REQ-019 SHALL compute offset = Addr - BASE and word index = offset[31:2].
REQ-020 SHALL flag misaligned (Exc=01) for half with Addr[0]=1, or word/reserved with Addr[1:0]!=0.
REQ-021 SHALL flag out of range (Exc=10) when offset >= 4*DEPTH; misaligned takes priority if both apply.
REQ-022 SHALL, on a flagged request, leave memory unchanged, return RData = 0, and still pulse Ack.
REQ-023 SHALL commit an accepted store on the accept edge, using byte enables from Size and Addr[1:0] (byte lane Addr[1:0], half lane Addr[1]); unselected bytes are preserved.
REQ-024 SHALL, for each committed store, emit a simulation trace "@<PC>: *<word-aligned Addr> <= <merged 32-bit word>" in hex.
REQ-025 SHALL register load reads: Ack and RData appear exactly 1 cycle after acceptance.
REQ-026 SHALL extract the selected byte/half from the read word and zero-extend it, or sign-extend it when Signed=1; word loads ignore Signed.
REQ-027 SHALL make a load accepted the cycle after a store to the same word return the post-store data.
REQ-028 SHALL drive Ack for stores 1 cycle after acceptance, with RData = 0.
REQ-029 SHALL drive Ack = 0, RData = 0 and Exc = 00 when no response is due.

Reset
REQ-030 SHALL, on Reset low, asynchronously force state = CLEAR, index = 0, Ready = 0, Ack = 0, RData = 0, Exc = 00.
REQ-031 SHALL begin the clear sweep on the first rising edge after Reset returns high.
REQ-032 SHALL drop any in-flight response on a reset mid-operation and restart the sweep from index 0 on a reset mid-CLEAR.
REQ-033 SHALL ignore Req while in CLEAR; no response is generated.

Verification
REQ-034 SHALL check clear: DEPTH=16, release Reset -> Ready rises after exactly 16 cycles; a word load of any address returns 0.
REQ-035 SHALL check byte/half merge: SW 0x11223344 @0x8, then SB 0xAA @0x9, then LW @0x8 -> 0x1122AA44; LH Signed=1 @0xA -> 0x00001122; LB Signed=1 @0x9 -> 0xFFFFFFAA; LB Signed=0 @0x9 -> 0x000000AA.
REQ-036 SHALL check back-to-back: SW 0xDEADBEEF @0x10 in cycle n, LW @0x10 in cycle n+1 -> Ack in n+2 with RData 0xDEADBEEF.
REQ-037 SHALL check exceptions: LW @0x6 -> Exc 01, RData 0; SH @0x3 -> Exc 01 and memory unchanged; LW @4*DEPTH -> Exc 10.
REQ-038 SHALL check reset mid-clear: assert Reset at cycle 5 of the sweep -> Ready stays 0 for a full DEPTH cycles after release.
REQ-039 SHALL check BASE=0x1000: SW @0x1004 then LW @0x1004 -> data returned; LW @0x0FFC -> Exc 10.

Source files
------------

// File: rtl/data_mem_pipe.sv
// data_mem_pipe: single-port data memory with a power-up clear sweep and byte/half/word loads and stores.
module data_mem_pipe #(
   parameter int          DEPTH = 3072,
   parameter logic [31:0] BASE  = 32'h0000_0000
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Req,
   input  logic        We,
   input  logic [31:0] Addr,
   input  logic [31:0] WData,
   input  logic [1:0]  Size,
   input  logic        Signed,
   input  logic [31:0] PC,
   output logic        Ready,
   output logic        Ack,
   output logic [31:0] RData,
   output logic [1:0]  Exc
);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   typedef enum logic {CLEAR, RUN} state_t;
   state_t        state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          ack_q, ack_d;
   logic [31:0]   rdata_q, rdata_d;
   logic [1:0]    exc_q, exc_d;
   logic [31:0]   mem_q [DEPTH];
   logic          mem_we;
   logic [IW-1:0] mem_wa;
   logic [31:0]   mem_wd;
   logic [29:0]   wofs;
   logic          misal, oor;
   logic [3:0]    be;
   logic [31:0]   old_w, sdata, merged, ext;
   logic [7:0]    byte_v;
   logic [15:0]   half_v;

   assign Ready = state_q == RUN;
   assign Ack   = ack_q;
   assign RData = rdata_q;
   assign Exc   = exc_q;

   // Address decode, store merge and load extraction against the current memory word
   always_comb begin
      wofs   = 30'((Addr - BASE) >> 2);
      oor    = wofs >= 30'(DEPTH);
      misal  = (Size == 2'b01 && Addr[0]) || (Size[1] && Addr[1:0] != 2'b00);
      old_w  = oor ? '0 : mem_q[wofs[IW-1:0]];
      be     = Size == 2'b00 ? 4'b0001 << Addr[1:0] : Size == 2'b01 ? (Addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      sdata  = Size == 2'b00 ? {4{WData[7:0]}} : Size == 2'b01 ? {2{WData[15:0]}} : WData;
      merged = old_w;
      for (int i = 0; i < 4; i++) merged[8*i +: 8] = be[i] ? sdata[8*i +: 8] : old_w[8*i +: 8];
      byte_v = old_w[{Addr[1:0], 3'b000} +: 8];
      half_v = Addr[1] ? old_w[31:16] : old_w[15:0];
      ext    = Size == 2'b00 ? {{24{Signed & byte_v[7]}}, byte_v} :
               Size == 2'b01 ? {{16{Signed & half_v[15]}}, half_v} : old_w;
   end

   // Clear sweep sequencing, request acceptance and next response
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      ack_d   = 1'b0;
      rdata_d = '0;
      exc_d   = 2'b00;
      mem_we  = 1'b0;
      mem_wa  = wofs[IW-1:0];
      mem_wd  = merged;
      if (state_q == CLEAR) begin
         mem_we  = 1'b1;
         mem_wa  = idx_q;
         mem_wd  = '0;
         idx_d   = idx_q == IW'(DEPTH - 1) ? '0 : idx_q + 1'b1;
         state_d = idx_q == IW'(DEPTH - 1) ? RUN : CLEAR;
      end else if (Req) begin
         ack_d   = 1'b1;
         exc_d   = misal ? 2'b01 : oor ? 2'b10 : 2'b00;
         mem_we  = We && !misal && !oor;
         rdata_d = (!We && !misal && !oor) ? ext : '0;
      end
   end

   // Control and response registers, cleared asynchronously so in-flight responses are dropped
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= CLEAR;
         idx_q   <= '0;
         ack_q   <= 1'b0;
         rdata_q <= '0;
         exc_q   <= 2'b00;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         ack_q   <= ack_d;
         rdata_q <= rdata_d;
         exc_q   <= exc_d;
      end
   end

   // Memory array write port shared by the clear sweep and committed stores
   always_ff @(posedge Clk) begin
      if (mem_we) mem_q[mem_wa] <= mem_wd;
   end

`ifndef SYNTHESIS
   // Store trace showing the merged word as committed
   always_ff @(posedge Clk) begin
      if (state_q == RUN && mem_we) $display("@%h: *%h <= %h", PC, {Addr[31:2], 2'b00}, mem_wd);
   end
`endif
endmodule
